bus_arbiter_rr: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 29 ++
 rtl/bus_arbiter_rr_if.sv | 40 ++++
 rtl/bus_arbiter_rr_pick.sv | 62 ++++++
 rtl/bus_arbiter_rr.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
package bus_arb_pkg;

   // Transfer sequencing states; every grant walks the full ring once.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_ADDR,
      ST_STROBE,
      ST_END
   } state_t;

   // Widest request vector the index helper accepts.
   localparam int MAX_MASTERS = 32;

   // Converts a one-hot (or all-zero) vector into the position of its set bit.
   // OR-ing the positions keeps the logic a flat encoder; all-zero yields 0.
   function automatic int unsigned onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (onehot[i]) begin
            idx = idx | int'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant/handshake bundle between the bus masters and the arbiter.
interface bus_arbiter_rr_if #(
   parameter int N_MASTERS = 4,
   parameter int IDXW      = $clog2(N_MASTERS)
) ();

   logic [N_MASTERS-1:0] BARQ;
   logic [N_MASTERS-1:0] BAGD;
   logic [IDXW-1:0]      GrantIdx;
   logic                 AddressValid;
   logic                 TargetReady;
   logic                 DataStrobe;
   logic                 Error;
   logic                 BusBusy;

   // Arbiter side: consumes requests and target ready, drives grants and strobes.
   modport slave (
      input  BARQ,
      input  TargetReady,
      output BAGD,
      output GrantIdx,
      output AddressValid,
      output DataStrobe,
      output Error,
      output BusBusy
   );

   // Requester / target side: mirror image of the arbiter view.
   modport master (
      output BARQ,
      output TargetReady,
      input  BAGD,
      input  GrantIdx,
      input  AddressValid,
      input  DataStrobe,
      input  Error,
      input  BusBusy
   );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner selection: fixed highest-index priority or round-robin
// search starting just above the last-served pointer.
module arb_pick
   import bus_arb_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int RR_MODE   = 1,
   parameter int IDXW      = $clog2(N_MASTERS)
) (
   input  logic [N_MASTERS-1:0] eligible,
   input  logic [IDXW-1:0]      pointer,
   output logic [N_MASTERS-1:0] onehot,
   output logic [IDXW-1:0]      index,
   output logic                 valid
);

   logic [IDXW-1:0]        win;
   logic [IDXW-1:0]        cand;
   logic                   found;
   logic [MAX_MASTERS-1:0] onehot_ext;

   // Search for the winning requester; the first hit in search order sticks.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      if (RR_MODE != 0) begin
         for (int off = 1; off <= N_MASTERS; off++) begin
            cand = IDXW'((int'(pointer) + off) % N_MASTERS);
            if (!found && eligible[cand]) begin
               found = 1'b1;
               win   = cand;
            end
         end
      end else begin
         // Later (higher) indices overwrite earlier ones, so the top requester wins.
         for (int i = 0; i < N_MASTERS; i++) begin
            if (eligible[i]) begin
               found = 1'b1;
               win   = IDXW'(i);
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_MASTERS; gi++) begin : g_onehot
         assign onehot[gi] = found && (win == IDXW'(gi));
      end
   endgenerate

   // Widen the grant vector so the shared encoder can produce the index.
   always_comb begin
      onehot_ext                 = '0;
      onehot_ext[N_MASTERS-1:0]  = onehot;
   end

   assign index = IDXW'(onehot_to_idx(onehot_ext));
   assign valid = found;

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: grant selection, address/strobe handshake with a
// timeout that forces the strobe and flags Error, plus a re-grant mask so a
// master has to release its request before it can win again.
module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int N_MASTERS      = 4,
   parameter int RR_MODE        = 1,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int IDXW           = $clog2(N_MASTERS)
) (
   input  logic            clk,
   input  logic            Reset,
   bus_arbiter_rr_if.slave bus
);

   localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
   localparam logic [IDXW-1:0] PTR_INIT = IDXW'(N_MASTERS - 1);

   state_t               state_reg,  state_next;
   logic [N_MASTERS-1:0] bagd_reg,   bagd_next;
   logic [IDXW-1:0]      idx_reg,    idx_next;
   logic                 av_reg,     av_next;
   logic                 ds_reg,     ds_next;
   logic                 err_reg,    err_next;
   logic                 busy_reg,   busy_next;
   logic [CNTW-1:0]      cnt_reg,    cnt_next;
   logic [N_MASTERS-1:0] mask_reg,   mask_next;
   logic [IDXW-1:0]      ptr_reg,    ptr_next;

   logic [N_MASTERS-1:0] eligible;
   logic [N_MASTERS-1:0] pick_onehot;
   logic [IDXW-1:0]      pick_idx;
   logic                 pick_valid;

   assign eligible = bus.BARQ & ~mask_reg;

   arb_pick #(
      .N_MASTERS (N_MASTERS),
      .RR_MODE   (RR_MODE),
      .IDXW      (IDXW)
   ) u_pick (
      .eligible (eligible),
      .pointer  (ptr_reg),
      .onehot   (pick_onehot),
      .index    (pick_idx),
      .valid    (pick_valid)
   );

   // Next-state and next-output decode; outputs are loaded with the values of
   // the state being entered so every port comes straight from a flop.
   always_comb begin
      state_next = state_reg;
      bagd_next  = bagd_reg;
      idx_next   = idx_reg;
      av_next    = av_reg;
      ds_next    = 1'b0;
      err_next   = 1'b0;
      cnt_next   = cnt_reg;
      mask_next  = mask_reg;
      ptr_next   = ptr_reg;

      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               state_next = ST_GRANT;
               bagd_next  = pick_onehot;
               idx_next   = pick_idx;
            end
         end
         ST_GRANT: begin
            state_next = ST_ADDR;
            av_next    = 1'b1;
         end
         ST_ADDR: begin
            cnt_next = cnt_reg + 1'b1;
            // Ready is checked first so a late ready on the last count is not an error.
            if (bus.TargetReady) begin
               state_next = ST_STROBE;
               ds_next    = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = ST_STROBE;
               ds_next    = 1'b1;
               err_next   = 1'b1;
            end
         end
         ST_STROBE: begin
            state_next        = ST_END;
            bagd_next         = '0;
            idx_next          = '0;
            av_next           = 1'b0;
            cnt_next          = '0;
            ptr_next          = idx_reg;
            mask_next[idx_reg] = 1'b1;
         end
         ST_END: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // A request that is low in any cycle re-arms that master.
      mask_next = mask_next & bus.BARQ;
      busy_next = (state_next != ST_IDLE);
   end

   // State, counter, mask, pointer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_reg <= ST_IDLE;
         bagd_reg  <= '0;
         idx_reg   <= '0;
         av_reg    <= 1'b0;
         ds_reg    <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         cnt_reg   <= '0;
         mask_reg  <= '0;
         ptr_reg   <= PTR_INIT;
      end else begin
         state_reg <= state_next;
         bagd_reg  <= bagd_next;
         idx_reg   <= idx_next;
         av_reg    <= av_next;
         ds_reg    <= ds_next;
         err_reg   <= err_next;
         busy_reg  <= busy_next;
         cnt_reg   <= cnt_next;
         mask_reg  <= mask_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign bus.BAGD         = bagd_reg;
   assign bus.GrantIdx     = idx_reg;
   assign bus.AddressValid = av_reg;
   assign bus.DataStrobe   = ds_reg;
   assign bus.Error        = err_reg;
   assign bus.BusBusy      = busy_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: one round-robin and one fixed-priority arbiter (both with a
// short timeout) share the same request/ready stimulus.
module tb_bus_arbiter_rr;

   logic       clk;
   logic       rst;
   logic [3:0] barq;
   logic       tready;

   int checks;
   int errors;

   bus_arbiter_rr_if #(.N_MASTERS(4)) if_rr ();
   bus_arbiter_rr_if #(.N_MASTERS(4)) if_fx ();

   assign if_rr.BARQ        = barq;
   assign if_rr.TargetReady = tready;
   assign if_fx.BARQ        = barq;
   assign if_fx.TargetReady = tready;

   bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
      .clk   (clk),
      .Reset (rst),
      .bus   (if_rr)
   );

   bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(0), .TIMEOUT_CYCLES(8)) dut_fx (
      .clk   (clk),
      .Reset (rst),
      .bus   (if_fx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] barq;
      logic       tready;
      logic [3:0] bagd;
      logic [1:0] idx;
      logic       av;
      logic       ds;
      logic       err;
      logic       busy;
   } vec_t;

   vec_t tbl[64];
   int   n_vec;

   function automatic vec_t mk(input logic r, input logic [3:0] b, input logic t,
                               input logic [3:0] eb, input logic [1:0] ei,
                               input logic eav, input logic eds, input logic eerr,
                               input logic ebusy);
      vec_t v;
      v.rst = r; v.barq = b; v.tready = t;
      v.bagd = eb; v.idx = ei; v.av = eav; v.ds = eds; v.err = eerr; v.busy = ebusy;
      return v;
   endfunction

   task automatic add(input vec_t v);
      tbl[n_vec] = v;
      n_vec++;
   endtask

   // Packed view {BAGD, GrantIdx, AddressValid, DataStrobe, Error, BusBusy}.
   function automatic logic [9:0] outs(input int sel);
      if (sel != 0)
         return {if_fx.BAGD, if_fx.GrantIdx, if_fx.AddressValid, if_fx.DataStrobe,
                 if_fx.Error, if_fx.BusBusy};
      return {if_rr.BAGD, if_rr.GrantIdx, if_rr.AddressValid, if_rr.DataStrobe,
              if_rr.Error, if_rr.BusBusy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end else begin
         $display("check %s ok ('h%0h)", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; barq = 4'b0000; tready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Waits (bounded) until the selected DUT shows a nonzero grant.
   task automatic wait_grant(input int sel, input string name, output logic [3:0] got);
      int k;
      k = 0;
      while (outs(sel)[9:6] == 4'b0000 && k < 60) begin
         tick();
         k++;
      end
      got = outs(sel)[9:6];
      if (got == 4'b0000) begin
         checks++; errors++;
         $display("FAIL %s: no grant within 60 cycles", name);
      end
   endtask

   // Waits (bounded) until the selected DUT is back in IDLE.
   task automatic wait_idle(input int sel, input string name);
      int k;
      k = 0;
      while (outs(sel)[0] == 1'b1 && k < 60) begin
         tick();
         k++;
      end
      if (outs(sel)[0] == 1'b1) begin
         checks++; errors++;
         $display("FAIL %s: still busy after 60 cycles", name);
      end
   endtask

   // Waits (bounded) until the round-robin DUT shows the given output bit high.
   task automatic wait_rr_bit(input int bitpos, input string name);
      int k;
      k = 0;
      while (outs(0)[bitpos] == 1'b0 && k < 60) begin
         tick();
         k++;
      end
      if (outs(0)[bitpos] == 1'b0) begin
         checks++; errors++;
         $display("FAIL %s: expected event within 60 cycles", name);
      end
   endtask

   initial begin
      logic [3:0] got;
      logic [3:0] got_fx;
      int         order[5];
      int         g;

      checks = 0; errors = 0; n_vec = 0;
      rst = 1'b1; barq = 4'b0000; tready = 1'b0;

      // Timeout transfer for master 1 (grant at row 1, strobe+error at row 10).
      add(mk(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, 0));
      add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 0, 0, 0, 1));
      add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, 0, 1));
      for (int i = 0; i < 7; i++) add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, 0, 1));
      add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 1, 1, 1));
      add(mk(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, 0, 1));
      add(mk(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, 0, 0));
      // Request still held: masked, no re-grant; dropping it re-arms.
      add(mk(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, 0, 0));
      add(mk(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, 0));
      // Ready arrives on the same edge the count hits its last value.
      add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 0, 0, 0, 1));
      add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, 0, 1));
      for (int i = 0; i < 7; i++) add(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, 0, 1));
      add(mk(0, 4'b0010, 1, 4'b0010, 2'd1, 1, 1, 0, 1));
      add(mk(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, 0, 1));
      add(mk(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, 0, 0));
      // Reset while in ADDR, then a fresh grant right after release.
      add(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 0, 0, 0, 1));
      add(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 0, 1));
      add(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 0, 1));
      add(mk(1, 4'b1000, 0, 4'b0000, 2'd0, 0, 0, 0, 0));
      add(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 0, 0, 0, 1));
      add(mk(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, 0));

      // Single requester at a time, so both arbitration modes must agree.
      for (int i = 0; i < n_vec; i++) begin
         rst = tbl[i].rst; barq = tbl[i].barq; tready = tbl[i].tready;
         tick();
         check($sformatf("vec%0d_rr", i), {22'd0, outs(0)},
               {22'd0, tbl[i].bagd, tbl[i].idx, tbl[i].av, tbl[i].ds, tbl[i].err, tbl[i].busy});
         check($sformatf("vec%0d_fx", i), {22'd0, outs(1)},
               {22'd0, tbl[i].bagd, tbl[i].idx, tbl[i].av, tbl[i].ds, tbl[i].err, tbl[i].busy});
      end

      // Fixed priority picks the highest requester; round-robin from reset picks 1.
      do_reset();
      barq = 4'b0110; tready = 1'b1;
      tick();
      check("fixed_first_grant", {28'd0, if_fx.BAGD}, 32'b0100);
      check("fixed_first_idx", {30'd0, if_fx.GrantIdx}, 32'd2);
      check("rr_first_grant", {28'd0, if_rr.BAGD}, 32'b0010);
      barq = 4'b0010;
      wait_idle(1, "fixed_release");
      wait_grant(1, "fixed_second", got);
      check("fixed_second_grant", {28'd0, got}, 32'b0010);

      // Round-robin fairness with all four requesting.
      do_reset();
      barq = 4'b1111;
      order = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         wait_grant(0, $sformatf("rr_wait%0d", k), got);
         g = int'(if_rr.GrantIdx);
         check($sformatf("rr_order%0d_grant", k), {28'd0, got}, 32'd1 << order[k]);
         check($sformatf("rr_order%0d_idx", k), g, order[k]);
         tready = 1'b0;
         wait_rr_bit(3, $sformatf("rr_av%0d", k));
         tready = 1'b1;
         wait_rr_bit(2, $sformatf("rr_ds%0d", k));
         tready = 1'b0;
         tick();
         barq[g[1:0]] = 1'b0;
         tick();
         barq = 4'b1111;
      end

      // A master held high through END is skipped until it releases once.
      do_reset();
      barq = 4'b0100; tready = 1'b1;
      wait_grant(0, "hold_first", got);
      got_fx = if_fx.BAGD;
      check("hold_first_rr", {28'd0, got}, 32'b0100);
      check("hold_first_fx", {28'd0, got_fx}, 32'b0100);
      wait_idle(0, "hold_idle1");
      for (int i = 0; i < 4; i++) tick();
      check("hold_no_regrant_rr", {22'd0, outs(0)}, 32'd0);
      check("hold_no_regrant_fx", {22'd0, outs(1)}, 32'd0);
      barq = 4'b0101;
      wait_grant(0, "hold_other", got);
      got_fx = if_fx.BAGD;
      check("hold_other_rr", {28'd0, got}, 32'b0001);
      check("hold_other_fx", {28'd0, got_fx}, 32'b0001);
      wait_idle(0, "hold_idle2");
      barq = 4'b0100;
      for (int i = 0; i < 3; i++) tick();
      check("hold_still_masked", {28'd0, if_rr.BAGD}, 32'd0);
      barq = 4'b0000;
      tick();
      barq = 4'b0100;
      wait_grant(0, "hold_regrant", got);
      check("hold_regrant_rr", {28'd0, got}, 32'b0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
